stream_demux1_3: RTL and testbench
==================================

Name: stream_demux1_3

Overview:
- Registered 1-to-3 stream demultiplexer; the routing counterpart of the datapath 3:1 selectors.
- Takes one valid/ready stream tagged with a 2-bit destination select and delivers each word to one of three output channels.
- Includes a 2-entry buffer (main + skid) for full throughput under backpressure.
- A select of 2'b11 is an illegal destination: the word is accepted, dropped and counted.

Parameters:
- N, 32, data width in bits
- CW, 8, width of the drop counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input word valid
- s_ready  out  1  block can accept a word
- s_data  in  N  input word
- s_sel  in  2  destination: 00→ch0, 01→ch1, 10→ch2, 11→drop
- m_valid  out  3  per-channel valid, bit k = channel k
- m_ready  in  3  per-channel ready, bit k = channel k
- m0_data  out  N  channel 0 data
- m1_data  out  N  channel 1 data
- m2_data  out  N  channel 2 data
- drop_cnt  out  CW  saturating count of dropped (sel=11) words

Behaviour:
- All state updates on rising clk. Reset is synchronous: rst_n low at an edge clears main_valid, skid_valid, main/skid data and sel, and drop_cnt.
- While rst_n is low, s_ready=0, m_valid=000, all m*_data=0.
- Reset mid-transfer discards buffered words. No output handshake completes in a cycle where rst_n is low.
- Storage:
  - main register {main_valid, main_sel, main_data}
  - skid register {skid_valid, skid_sel, skid_data}
- s_ready = rst_n & ~skid_valid. It is registered-derived, with no combinational path from m_ready.
- Accept: acc = s_valid & s_ready.
- Drop: if acc and s_sel==11, the word is not stored and drop_cnt increments, saturating at 2^CW-1.
- Output: m_valid[k] = main_valid & (main_sel==k).
  - mk_data = main_data when m_valid[k], else 0 (mux default-zero convention).
- Pop: pop = main_valid & m_ready[main_sel]. Ready bits of non-selected channels are ignored.
- Next-state priority each cycle. Let acc_st = acc & (s_sel!=11).
  - If (!main_valid | pop):
    - if skid_valid, main ← skid and skid_valid ← acc_st (skid ← input if acc_st);
    - else main ← input with main_valid ← acc_st.
  - Else (main held): if acc_st, skid ← input. acc_st cannot occur while skid_valid, by s_ready.
- Latency: an accepted word with an empty buffer appears on its channel the next cycle.
- Throughput: 1 word/cycle with the destination always ready.
- Ordering: words leave in acceptance order across all channels. This is strict FIFO, so head-of-line blocking is intended.
- Simultaneous pop and accept with skid full cannot happen, because s_ready=0 in that case. Pop plus accept with skid empty and main valid loads the new word into main.
- Dropped word while buffer full: impossible, since s_ready=0 blocks it. A drop is counted only on acceptance.
- A data or select change while s_valid=1 and s_ready=0 is a protocol violation. It is not checked by the block; an assertion is allowed in simulation only.

Decomposition:
- Shared package stream_pkg:
  - typedef enum logic [1:0] dest_e {DEST_CH0, DEST_CH1, DEST_CH2, DEST_DROP}
  - localparam NUM_CH = 3
- One natural sub-module: skid_buffer (N+2 bits wide, 2-entry valid/ready slice). stream_demux1_3 wraps it with the drop filter, routing decode and drop counter.

Test Plan:
- Reset then stream: rst_n low 2 cycles → s_ready=0, m_valid=000. Release, send 0xA5A5_0001 sel=01 → next cycle m_valid=010, m1_data=0xA5A5_0001, m0_data=m2_data=0.
- Full throughput: m_ready=111, 30 back-to-back words with sel cycling 00/01/10 → each appears 1 cycle after acceptance on the correct channel, s_ready held 1, no bubbles.
- Backpressure: m_ready=000, send words W0 (sel 10) and W1 (sel 00) → s_ready falls after the 2nd accept. Raise m_ready[0] only → nothing pops (W0 targets ch2). Raise m_ready[2] → W0 then W1 out in order, s_ready returns 1.
- Drop: send 5 words sel=11 interleaved with 2 words sel=00 → drop_cnt=5, only the 2 words appear on ch0. Preload drop_cnt near 255 (CW=8) via 300 drops → saturates at 255.
- Reset mid-operation: buffer full (skid_valid=1), assert rst_n for 1 cycle → m_valid=000, s_ready=0 during reset, drop_cnt=0. The buffered words never appear after release.
- Random: 10k cycles of random s_valid/s_sel/m_ready → scoreboard shows per-channel order preserved, no loss or duplication, drop_cnt matches the count of accepted sel=11 words.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: destination encoding and channel count shared by the stream demux blocks
package stream_pkg;
    typedef enum logic [1:0] {DEST_CH0, DEST_CH1, DEST_CH2, DEST_DROP} dest_e;
    localparam int NUM_CH = 3;
endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: 2-entry (main + skid) valid/ready slice; in_ready depends only on registered state
module skid_buffer #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);
    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic         push, pop;
    assign in_ready_o  = rst_n & ~skid_valid_q;
    assign push        = in_valid_i & in_ready_o;
    assign out_valid_o = rst_n & main_valid_q;
    assign out_data_o  = main_data_q;
    assign pop         = out_valid_o & out_ready_i;
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = push;
                skid_data_d  = push ? in_data_i : skid_data_q;
            end else begin
                main_valid_d = push;
                main_data_d  = push ? in_data_i : main_data_q;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end
endmodule

// File: rtl/stream_demux1_3.sv
// stream_demux1_3: registered 1-to-3 stream demux; select 11 words are accepted, dropped and counted
module stream_demux1_3
    import stream_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N-1:0]      s_data,
    input  logic [1:0]        s_sel,
    output logic [NUM_CH-1:0] m_valid,
    input  logic [NUM_CH-1:0] m_ready,
    output logic [N-1:0]      m0_data,
    output logic [N-1:0]      m1_data,
    output logic [N-1:0]      m2_data,
    output logic [CW-1:0]     drop_cnt
);
    logic          buf_valid, acc, drop;
    logic [N+1:0]  buf_data;
    logic [N-1:0]  main_data;
    dest_e         in_dest, main_dest;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    assign in_dest = dest_e'(s_sel);
    assign acc     = s_valid & s_ready;
    assign drop    = acc & (in_dest == DEST_DROP);
    // the select travels with the word so routing is decoded from the registered head
    skid_buffer #(.W(N + 2)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s_valid & (in_dest != DEST_DROP)),
        .in_data_i   ({s_sel, s_data}),
        .in_ready_o  (s_ready),
        .out_valid_o (buf_valid),
        .out_data_o  (buf_data),
        .out_ready_i (|(m_valid & m_ready))
    );
    assign main_dest  = dest_e'(buf_data[N+1:N]);
    assign main_data  = buf_data[N-1:0];
    assign m_valid[0] = buf_valid & (main_dest == DEST_CH0);
    assign m_valid[1] = buf_valid & (main_dest == DEST_CH1);
    assign m_valid[2] = buf_valid & (main_dest == DEST_CH2);
    assign m0_data    = m_valid[0] ? main_data : '0;
    assign m1_data    = m_valid[1] ? main_data : '0;
    assign m2_data    = m_valid[2] ? main_data : '0;
    assign drop_cnt_d = (drop && drop_cnt_q != '1) ? drop_cnt_q + CW'(1) : drop_cnt_q;
    assign drop_cnt   = drop_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end
endmodule

// File: tb/tb_stream_demux1_3.sv
// tb_stream_demux1_3: random and directed stimulus checked against a 2-deep FIFO reference model
module tb_stream_demux1_3;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [1:0]  s_sel = '0;
    logic [2:0]  m_valid;
    logic [2:0]  m_ready = '0;
    logic [31:0] m0_data, m1_data, m2_data;
    logic [7:0]  drop_cnt;
    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int   exp_drop = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    stream_demux1_3 #(.N(32), .CW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sel    (s_sel),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m0_data  (m0_data),
        .m1_data  (m1_data),
        .m2_data  (m2_data),
        .drop_cnt (drop_cnt)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // One clock: drive inputs, check outputs against the model, advance the model across the edge
    task automatic step(input logic r, input logic v, input logic [1:0] sel,
                        input logic [31:0] d, input logic [2:0] mr);
        logic        rdy;
        logic [2:0]  ev;
        logic [31:0] ed [3];
        @(negedge clk);
        rst_n = r; s_valid = v; s_sel = sel; s_data = d; m_ready = mr;
        #1;
        rdy = r && (q.size() < 2);
        ev = '0;
        ed = '{default: '0};
        if (r && q.size() > 0) begin
            ev[q[0].sel] = 1'b1;
            ed[q[0].sel] = q[0].data;
        end
        check("s_ready", s_ready, rdy);
        check("m_valid", m_valid, ev);
        check("m0_data", m0_data, ed[0]);
        check("m1_data", m1_data, ed[1]);
        check("m2_data", m2_data, ed[2]);
        check("drop_cnt", drop_cnt, exp_drop);
        if (!r) begin
            q.delete();
            exp_drop = 0;
        end else begin
            if (q.size() > 0 && mr[q[0].sel]) void'(q.pop_front());
            if (v && rdy) begin
                if (sel == 2'b11) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
                else q.push_back('{sel, d});
            end
        end
        @(posedge clk);
    endtask
    initial begin
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h1234, 3'b111);
        step(1, 1, 2'b01, 32'hA5A5_0001, 3'b000);
        step(1, 0, 0, 0, 3'b000);
        #1;
        check("first_m_valid", m_valid, 3'b010);
        check("first_m1", m1_data, 32'hA5A5_0001);
        step(1, 0, 0, 0, 3'b111);
        // full throughput
        for (int i = 0; i < 30; i++) step(1, 1, 2'(i % 3), 32'hB000_0000 + i, 3'b111);
        step(1, 0, 0, 0, 3'b111);
        // backpressure with head-of-line blocking
        step(1, 1, 2'b10, 32'hC0C0_0000, 3'b000);
        step(1, 1, 2'b00, 32'hC0C0_0001, 3'b000);
        #1;
        check("bp_ready_low", s_ready, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 1, 2'b01, 32'hDEAD, 3'b001);
        #1;
        check("bp_hol_ch2", m2_data, 32'hC0C0_0000);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 3'b100);
        step(1, 0, 0, 0, 3'b001);
        step(1, 0, 0, 0, 3'b111);
        // drops interleaved with ch0 words
        for (int i = 0; i < 7; i++)
            step(1, 1, (i == 2 || i == 5) ? 2'b00 : 2'b11, 32'hD000_0000 + i, 3'b111);
        step(1, 0, 0, 0, 3'b111);
        #1;
        check("drop_five", drop_cnt, 8'd5);
        for (int i = 0; i < 300; i++) step(1, 1, 2'b11, i, 3'b111);
        step(1, 0, 0, 0, 3'b111);
        #1;
        check("drop_sat", drop_cnt, 8'd255);
        // reset with both entries full
        step(1, 1, 2'b00, 32'hE000_0000, 3'b000);
        step(1, 1, 2'b01, 32'hE000_0001, 3'b000);
        step(0, 1, 2'b10, 32'hE000_0002, 3'b111);
        #1;
        check("rst_mid_drop", drop_cnt, 8'd0);
        check("rst_mid_valid", m_valid, 3'b000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 3'b111);
        // random traffic with occasional resets
        for (int i = 0; i < 10000; i++)
            step($urandom_range(0, 999) != 0, 1'($urandom), 2'($urandom), $urandom, 3'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
